// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the HH:MM:SS mode/setup sequencer.
//   mode_e        : sequencer state, also driven out as o_mode
//   MASK_*        : blink-mask constants; bit pairs [1:0] sec, [3:2] min, [5:4] hour
//   pair_sel()    : mask bits belonging to the digit pair edited in a given mode
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK    = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_e;

  localparam logic [5:0] MASK_ALL_ON = 6'b111111;
  localparam logic [5:0] MASK_SEC    = 6'b000011;
  localparam logic [5:0] MASK_MIN    = 6'b001100;
  localparam logic [5:0] MASK_HOUR   = 6'b110000;

  function automatic logic [5:0] pair_sel(input mode_e m);
    case (m)
      MODE_SET_SEC:  return MASK_SEC;
      MODE_SET_MIN:  return MASK_MIN;
      MODE_SET_HOUR: return MASK_HOUR;
      default:       return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/hms_set_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
//   clk, rst : system clock, synchronous active-high reset
//   level    : debounced button level, 1 = pressed
//   rise     : combinational, high in the cycle the level first reads 1
// The previous-level register resets to 1 so a button held through reset
// produces no edge when reset is released.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/hms_set_ctrl.sv
// Mode/setup sequencer for the HH:MM:SS clock datapath. Turns button levels
// and 1 Hz / 100 Hz tick enables into one-cycle counter enables and a
// per-digit blink mask; everything runs on the single clock clk.
//   i_tick_1hz, i_tick_100hz       : one-cycle tick enables
//   i_sw_mode, i_sw_pos, i_sw_inc  : debounced button levels
//   i_max_hit_sec, i_max_hit_min   : counter wrap pulses (carry in CLOCK)
//   o_mode                         : 0 CLOCK, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
//   o_sec_inc, o_min_inc, o_hour_inc : registered counter enables
//   o_blink_mask                   : 1 = digit visible
module hms_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S  = 30,
  parameter int BLINK_HALF = 25,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_1hz,
  input  logic       i_tick_100hz,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [5:0] o_blink_mask
);

  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int TMO_W   = $clog2(TIMEOUT_S + 1);
  localparam int BLK_W   = $clog2(BLINK_HALF + 1);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // Each counter fires on the tick that would bring it to its parameter value.
  localparam logic [TMO_W-1:0] TMO_TOP = TMO_W'(TIMEOUT_S - 1);
  localparam logic [BLK_W-1:0] BLK_TOP = BLK_W'(BLINK_HALF - 1);
  localparam logic [REP_W-1:0] DLY_TOP = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] PER_TOP = REP_W'(REPEAT_PER - 1);

  mode_e            state_q, state_d;
  logic             mode_rise, pos_rise, inc_rise;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_en_q, rep_en_d, rep_arm_q, rep_arm_d, rep_fire;
  logic             sec_d, min_d, hour_d;
  logic [5:0]       mask_d;
  logic             in_set, any_edge, tmo_expire, inc_take;

  btn_edge u_mode (.clk(clk), .rst(rst), .level(i_sw_mode), .rise(mode_rise));
  btn_edge u_pos  (.clk(clk), .rst(rst), .level(i_sw_pos),  .rise(pos_rise));
  btn_edge u_inc  (.clk(clk), .rst(rst), .level(i_sw_inc),  .rise(inc_rise));

  assign in_set     = (state_q != MODE_CLOCK);
  assign any_edge   = mode_rise | pos_rise | inc_rise;
  // A button edge in the same cycle overrides an expiring timeout.
  assign tmo_expire = in_set & i_tick_1hz & ~any_edge & (tmo_q >= TMO_TOP);
  // Mode edge swallows a coincident inc edge.
  assign inc_take   = in_set & inc_rise & ~mode_rise;

  always_comb begin
    state_d = state_q;
    if (mode_rise) begin
      state_d = in_set ? MODE_CLOCK : MODE_SET_SEC;
    end else if (in_set && pos_rise) begin
      case (state_q)
        MODE_SET_SEC: state_d = MODE_SET_MIN;
        MODE_SET_MIN: state_d = MODE_SET_HOUR;
        default:      state_d = MODE_SET_SEC;
      endcase
    end else if (tmo_expire) begin
      state_d = MODE_CLOCK;
    end

    // Idle timeout: counts 1 Hz ticks only while sitting in one SET state.
    tmo_d = tmo_q;
    if (!in_set || any_edge || (state_d != state_q)) tmo_d = '0;
    else if (i_tick_1hz)                            tmo_d = tmo_q + 1'b1;

    // Blink phase runs in every state so the rhythm is continuous.
    blk_d   = blk_q;
    phase_d = phase_q;
    if (i_tick_100hz) begin
      if (blk_q >= BLK_TOP) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    // Auto-repeat: armed only by an accepted inc edge; a release or any
    // state change disarms it until the next edge.
    rep_d     = rep_q;
    rep_en_d  = rep_en_q;
    rep_arm_d = rep_arm_q;
    rep_fire  = 1'b0;
    if (!i_sw_inc || !in_set || (state_d != state_q)) begin
      rep_d     = '0;
      rep_en_d  = 1'b0;
      rep_arm_d = 1'b0;
    end else if (inc_take) begin
      rep_d     = '0;
      rep_en_d  = 1'b1;
      rep_arm_d = 1'b0;
    end else if (rep_en_q && i_tick_100hz) begin
      if (rep_q >= (rep_arm_q ? PER_TOP : DLY_TOP)) begin
        rep_fire  = 1'b1;
        rep_d     = '0;
        rep_arm_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end

    sec_d  = 1'b0;
    min_d  = 1'b0;
    hour_d = 1'b0;
    if (!in_set) begin
      sec_d  = i_tick_1hz;
      min_d  = i_max_hit_sec;
      hour_d = i_max_hit_min;
    end else if (inc_take || rep_fire) begin
      // Pulses go to the position selected before any coincident advance.
      case (state_q)
        MODE_SET_SEC: sec_d  = 1'b1;
        MODE_SET_MIN: min_d  = 1'b1;
        default:      hour_d = 1'b1;
      endcase
    end

    // Mask follows the next state so it lines up with o_mode.
    mask_d = MASK_ALL_ON;
    if ((state_d != MODE_CLOCK) && !phase_d && !i_sw_inc)
      mask_d = MASK_ALL_ON & ~pair_sel(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MODE_CLOCK;
      tmo_q        <= '0;
      blk_q        <= '0;
      phase_q      <= 1'b1;
      rep_q        <= '0;
      rep_en_q     <= 1'b0;
      rep_arm_q    <= 1'b0;
      o_sec_inc    <= 1'b0;
      o_min_inc    <= 1'b0;
      o_hour_inc   <= 1'b0;
      o_blink_mask <= MASK_ALL_ON;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      blk_q        <= blk_d;
      phase_q      <= phase_d;
      rep_q        <= rep_d;
      rep_en_q     <= rep_en_d;
      rep_arm_q    <= rep_arm_d;
      o_sec_inc    <= sec_d;
      o_min_inc    <= min_d;
      o_hour_inc   <= hour_d;
      o_blink_mask <= mask_d;
    end
  end

  assign o_mode = state_q;

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Directed bench for hms_set_ctrl: expected counter-enable pulses are queued
// with their cycle stamp when stimulus is driven; a negedge monitor pops and
// compares whenever a pulse is due or presented. Mode and mask are checked
// directly against hand-computed values.
module tb_hms_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       t1, t100, sw_mode, sw_pos, sw_inc, mhs, mhm;
  logic [1:0] o_mode;
  logic       o_sec_inc, o_min_inc, o_hour_inc;
  logic [5:0] o_blink_mask;

  hms_set_ctrl #(
    .TIMEOUT_S(3), .BLINK_HALF(2), .REPEAT_DLY(4), .REPEAT_PER(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_tick_1hz(t1), .i_tick_100hz(t100),
    .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
    .i_max_hit_sec(mhs), .i_max_hit_min(mhm),
    .o_mode(o_mode), .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc),
    .o_hour_inc(o_hour_inc), .o_blink_mask(o_blink_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] p;   // {hour, min, sec}
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] act;
      ev_t e;
      act = {o_hour_inc, o_min_inc, o_sec_inc};
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL pulse_missing@%0d got none expected %b", e.at, e.p);
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (act !== e.p) begin
          n_fail++;
          $display("FAIL pulse@%0d got %b expected %b", cyc, act, e.p);
        end
      end else if (act != 3'b000) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse_unexpected@%0d got %b expected 000", cyc, act);
      end
    end
  end

  // Drive current inputs for one clock; queue the pulses they must cause.
  task automatic step(input logic [2:0] exp);
    if (exp != 3'b000) q.push_back('{at: cyc + 1, p: exp});
    @(negedge clk);
    t1 = 1'b0; t100 = 1'b0; mhs = 1'b0; mhm = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mode(input string name, input logic [1:0] exp);
    chk(name, {6'd0, o_mode}, {6'd0, exp});
  endtask

  task automatic chk_mask(input string name, input logic [5:0] exp);
    chk(name, {2'd0, o_blink_mask}, {2'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sw_mode = 1'b1; sw_pos = 1'b0; sw_inc = 1'b0;
    t1 = 1'b0; t100 = 1'b0; mhs = 1'b0; mhm = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(3'b000);
    chk_mode("reset_mode", 2'd0);
    chk_mask("reset_mask", 6'h3F);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(3'b000);
    chk_mode("held_mode_no_edge", 2'd0);
    chk_mask("held_mode_mask", 6'h3F);
    sw_mode = 1'b0; step(3'b000);

    // CLOCK: ticks and carry
    for (int i = 0; i < 5; i++) begin
      t1 = 1'b1;
      if (i == 2) begin mhs = 1'b1; step(3'b011); end
      else step(3'b001);
      step(3'b000);
    end
    sw_inc = 1'b1; step(3'b000);
    sw_inc = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000);
    chk_mode("clock_pos_ignored", 2'd0);
    sw_pos = 1'b0; step(3'b000);

    // Enter setup and cycle positions
    sw_mode = 1'b1; step(3'b000); chk_mode("enter_set_sec", 2'd1);
    sw_mode = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_to_min", 2'd2);
    sw_pos = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_to_hour", 2'd3);
    sw_pos = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_wrap_sec", 2'd1);
    sw_pos = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_to_min2", 2'd2);
    sw_pos = 1'b0; step(3'b000);
    sw_inc = 1'b1; t1 = 1'b1; step(3'b010);
    sw_inc = 1'b0; step(3'b000);
    t1 = 1'b1; mhs = 1'b1; mhm = 1'b1; step(3'b000);
    chk_mode("set_ignores_ticks", 2'd2);

    // Auto-repeat in SET_HOUR
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_to_hour2", 2'd3);
    sw_pos = 1'b0; step(3'b000);
    sw_inc = 1'b1; step(3'b100);
    for (int k = 1; k <= 10; k++) begin
      t100 = 1'b1;
      step((k >= 4 && k % 2 == 0) ? 3'b100 : 3'b000);
      step(3'b000);
      chk_mask($sformatf("hold_mask_k%0d", k), 6'h3F);
    end
    sw_inc = 1'b0; step(3'b000);
    chk_mask("release_mask_hour_off", 6'h0F);

    // Blink and timeout in SET_SEC
    sw_mode = 1'b1; step(3'b000); chk_mode("hour_to_clock", 2'd0);
    chk_mask("clock_mask", 6'h3F);
    sw_mode = 1'b0; step(3'b000);
    sw_mode = 1'b1; step(3'b000); chk_mode("enter_set_sec2", 2'd1);
    chk_mask("blink_start", 6'h3C);
    sw_mode = 1'b0; step(3'b000);
    t100 = 1'b1; step(3'b000); chk_mask("blink_t1", 6'h3C);
    t100 = 1'b1; step(3'b000); chk_mask("blink_t2", 6'h3F);
    t100 = 1'b1; step(3'b000); chk_mask("blink_t3", 6'h3F);
    t100 = 1'b1; step(3'b000); chk_mask("blink_t4", 6'h3C);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_1", 2'd1);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_2", 2'd1);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_3_clock", 2'd0);
    chk_mask("tmo_mask", 6'h3F);

    // Mode + inc edges together in SET_MIN
    sw_mode = 1'b1; step(3'b000); chk_mode("enter_set_sec3", 2'd1);
    sw_mode = 1'b0; step(3'b000);
    sw_pos = 1'b1; step(3'b000); chk_mode("pos_to_min3", 2'd2);
    sw_pos = 1'b0; step(3'b000);
    sw_mode = 1'b1; sw_inc = 1'b1; step(3'b000);
    chk_mode("mode_beats_inc", 2'd0);
    sw_mode = 1'b0; sw_inc = 1'b0; step(3'b000);

    // Timeout tick coincident with a position edge
    sw_mode = 1'b1; step(3'b000); chk_mode("enter_set_sec4", 2'd1);
    sw_mode = 1'b0; step(3'b000);
    t1 = 1'b1; step(3'b000);
    t1 = 1'b1; step(3'b000);
    t1 = 1'b1; sw_pos = 1'b1; step(3'b000);
    chk_mode("edge_beats_tmo", 2'd2);
    sw_pos = 1'b0; step(3'b000);
    sw_pos = 1'b1; sw_inc = 1'b1; step(3'b010);
    chk_mode("pos_inc_advance", 2'd3);
    sw_pos = 1'b0; sw_inc = 1'b0; step(3'b000);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_restart_1", 2'd3);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_restart_2", 2'd3);
    t1 = 1'b1; step(3'b000); chk_mode("tmo_restart_3", 2'd0);

    // CLOCK carry into hours
    mhm = 1'b1; step(3'b100);
    t1 = 1'b1; step(3'b001);
    for (int i = 0; i < 3; i++) step(3'b000);

    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL pulse_missing@%0d got none expected %b", e.at, e.p);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
